// File: rtl/time_unit_counter.sv
// time_unit_counter: one field of the millennium clock (seconds .. year).
// Counts MIN_VAL..eff_max with wrap and a one-cycle carry to the next field.
// When selected for setting, counting freezes and up/down edges step the value.
module time_unit_counter #(
    parameter int unsigned      WIDTH       = 6,
    parameter int unsigned      MIN_VAL     = 0,
    parameter int unsigned      MAX_VAL     = 59,
    parameter bit               USE_DYN_MAX = 1'b0,
    parameter int unsigned      SEL_W       = 3,
    parameter logic [SEL_W-1:0] SELECT_CODE = '0
) (
    input  logic             clk_1Hz,
    input  logic             rst_n,
    input  logic             en_1,
    input  logic             up,
    input  logic             down,
    input  logic [SEL_W-1:0] select_item,
    input  logic [WIDTH-1:0] max_dyn,
    output logic [WIDTH-1:0] value,
    output logic             carry_out,
    output logic             adj_active
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic             up_q;
    logic             down_q;
    logic [WIDTH-1:0] dyn_bound;
    logic [WIDTH-1:0] eff_max;
    logic             adj;
    logic             up_rise;
    logic             down_rise;
    logic [WIDTH-1:0] value_nxt;
    logic             carry_nxt;

    // Dynamic bound is floored at MIN_VAL so a bogus max_dyn cannot strand the field
    assign dyn_bound = (int'(max_dyn) < int'(MIN_VAL)) ? MIN_V : max_dyn;
    assign eff_max   = USE_DYN_MAX ? dyn_bound : MAX_V;

    assign adj       = (select_item == SELECT_CODE);
    assign up_rise   = up & ~up_q;
    assign down_rise = down & ~down_q;

    // Next value and carry: count mode wraps/clamps, adjust mode steps on button edges
    always_comb begin
        value_nxt = value;
        carry_nxt = 1'b0;
        if (!adj) begin
            if (en_1) begin
                if (value >= eff_max) begin
                    value_nxt = MIN_V;
                    carry_nxt = 1'b1;
                end else begin
                    value_nxt = value + ONE;
                end
            end else if (value > eff_max) begin
                value_nxt = eff_max;
            end
        end else begin
            if (value > eff_max) begin
                value_nxt = eff_max;
            end else if (up_rise && !down_rise) begin
                value_nxt = (value == eff_max) ? MIN_V : value + ONE;
            end else if (down_rise && !up_rise) begin
                value_nxt = (value == MIN_V) ? eff_max : value - ONE;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_1Hz) begin
        if (!rst_n) begin
            value      <= MIN_V;
            carry_out  <= 1'b0;
            adj_active <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
        end else begin
            value      <= value_nxt;
            carry_out  <= carry_nxt;
            adj_active <= adj;
            up_q       <= up;
            down_q     <= down;
        end
    end

endmodule

// File: tb/tb_time_unit_counter.sv
// Scoreboard bench for time_unit_counter: a default seconds field (A) and a
// dynamic-bound day field (B) run side by side against a behavioural model.
module tb_time_unit_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en_a, up_a, dn_a;
    logic [2:0] sel_a;
    logic [5:0] max_a;
    logic [5:0] value_a;
    logic       carry_a, adj_a;

    logic       en_b, up_b, dn_b;
    logic [2:0] sel_b;
    logic [4:0] max_b;
    logic [4:0] value_b;
    logic       carry_b, adj_b;

    time_unit_counter dut_a (
        .clk_1Hz(clk), .rst_n(rst_n), .en_1(en_a), .up(up_a), .down(dn_a),
        .select_item(sel_a), .max_dyn(max_a),
        .value(value_a), .carry_out(carry_a), .adj_active(adj_a)
    );

    time_unit_counter #(
        .WIDTH(5), .MIN_VAL(1), .MAX_VAL(31), .USE_DYN_MAX(1'b1),
        .SEL_W(3), .SELECT_CODE(3'b010)
    ) dut_b (
        .clk_1Hz(clk), .rst_n(rst_n), .en_1(en_b), .up(up_b), .down(dn_b),
        .select_item(sel_b), .max_dyn(max_b),
        .value(value_b), .carry_out(carry_b), .adj_active(adj_b)
    );

    typedef struct {
        int val;
        int carry;
        int adj;
        int upq;
        int dnq;
    } mstate_t;

    typedef struct {
        int val;
        int carry;
        int adj;
    } exp_t;

    mstate_t ms_a, ms_b;
    exp_t    q_a[$];
    exp_t    q_b[$];
    int      tests = 0;
    int      fails = 0;
    int      carry_seen_a = 0;

    // Field behaviour from the rules: range arithmetic done modulo the span
    function automatic mstate_t model_step(mstate_t s, int minv, int eff, bit rst,
                                           bit en, bit up, bit dn, bit sel);
        mstate_t n;
        int      span;
        bit      ur, dr;
        n = s;
        if (!rst) begin
            n.val = minv; n.carry = 0; n.adj = 0; n.upq = 0; n.dnq = 0;
            return n;
        end
        ur = up && (s.upq == 0);
        dr = dn && (s.dnq == 0);
        n.upq = int'(up);
        n.dnq = int'(dn);
        n.adj = int'(sel);
        n.carry = 0;
        span = eff - minv + 1;
        if (!sel) begin
            if (en) begin
                if (s.val >= eff) begin
                    n.val = minv;
                    n.carry = 1;
                end else begin
                    n.val = s.val + 1;
                end
            end else if (s.val > eff) begin
                n.val = eff;
            end
        end else begin
            if (s.val > eff) n.val = eff;
            else if (ur && !dr) n.val = minv + ((s.val - minv + 1) % span);
            else if (dr && !ur) n.val = minv + ((s.val - minv - 1 + span) % span);
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the current inputs for one clock: predict, enqueue, advance
    task automatic tick();
        int eff_b;
        eff_b = (int'(max_b) < 1) ? 1 : int'(max_b);
        ms_a = model_step(ms_a, 0, 59, rst_n, en_a, up_a, dn_a, sel_a == 3'b000);
        ms_b = model_step(ms_b, 1, eff_b, rst_n, en_b, up_b, dn_b, sel_b == 3'b010);
        q_a.push_back('{ms_a.val, ms_a.carry, ms_a.adj});
        q_b.push_back('{ms_b.val, ms_b.carry, ms_b.adj});
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        en_a = 0; up_a = 0; dn_a = 0; sel_a = 3'd7; max_a = 6'd0;
        en_b = 0; up_b = 0; dn_b = 0; sel_b = 3'd7; max_b = 5'd31;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    // Monitor: every edge the DUTs present a new output word
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("a.value", int'(value_a), e.val);
            check("a.carry_out", int'(carry_a), e.carry);
            check("a.adj_active", int'(adj_a), e.adj);
            if (carry_a) carry_seen_a++;
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("b.value", int'(value_b), e.val);
            check("b.carry_out", int'(carry_b), e.carry);
            check("b.adj_active", int'(adj_b), e.adj);
        end
    end

    initial begin
        ms_a = '{0, 0, 0, 0, 0};
        ms_b = '{0, 0, 0, 0, 0};
        idle_inputs();
        rst_n = 0;

        // Full seconds sweep: exactly one carry on the 59 -> 0 wrap
        do_reset();
        carry_seen_a = 0;
        en_a = 1;
        for (int i = 0; i < 60; i++) tick();
        en_a = 0;
        tick();
        check("sweep.final_value", int'(value_a), 0);
        check("sweep.carry_count", carry_seen_a, 1);

        // Day field: shrink bound 31 -> 28 clamps, then en_1 wraps to 1 with carry
        idle_inputs();
        do_reset();
        en_b = 1;
        for (int i = 0; i < 30; i++) tick();
        en_b = 0;
        check("day.at_31", int'(value_b), 31);
        max_b = 5'd28;
        tick();
        check("day.clamped", int'(value_b), 28);
        en_b = 1;
        tick();
        en_b = 0;
        check("day.wrap_carry", int'(carry_b), 1);
        max_b = 5'd0;
        tick();
        check("day.floor_min", int'(value_b), 1);

        // Adjust: down wraps 0 -> 59, held up steps once, en_1 ignored
        idle_inputs();
        do_reset();
        sel_a = 3'b000; dn_a = 1; en_a = 1;
        tick();
        check("adj.down_wrap", int'(value_a), 59);
        dn_a = 0;
        tick();
        up_a = 1;
        for (int i = 0; i < 5; i++) begin
            en_a = i[0];
            tick();
        end
        check("adj.held_up_once", int'(value_a), 0);
        up_a = 0; en_a = 0;
        tick();

        // Simultaneous edges hold; button held across selection gives no edge
        idle_inputs();
        do_reset();
        en_a = 1;
        for (int i = 0; i < 30; i++) tick();
        en_a = 0;
        sel_a = 3'b000; up_a = 1; dn_a = 1;
        tick();
        check("adj.both_hold", int'(value_a), 30);
        up_a = 0; dn_a = 0;
        tick();
        sel_a = 3'd7; up_a = 1;
        tick();
        sel_a = 3'b000;
        tick();
        check("adj.held_into_select", int'(value_a), 30);
        up_a = 0;
        tick();
        up_a = 1;
        tick();
        check("adj.repress", int'(value_a), 31);
        idle_inputs();
        tick();

        // Reset wins over a wrapping en_1
        do_reset();
        en_a = 1;
        for (int i = 0; i < 59; i++) tick();
        rst_n = 0;
        tick();
        check("rst.over_carry", int'(carry_a), 0);
        rst_n = 1;
        tick();
        check("rst.resume", int'(value_a), 1);
        en_a = 0;

        // Randomised traffic on both fields
        idle_inputs();
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            en_a  = ($urandom_range(0, 2) == 0);
            en_b  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) up_a = ~up_a;
            if ($urandom_range(0, 3) == 0) dn_a = ~dn_a;
            if ($urandom_range(0, 3) == 0) up_b = ~up_b;
            if ($urandom_range(0, 3) == 0) dn_b = ~dn_b;
            if ($urandom_range(0, 15) == 0)
                sel_a = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0)
                sel_b = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                max_b = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(28, 31));
            max_a = 6'($urandom_range(0, 63));
            tick();
        end

        check("drain.a", q_a.size(), 0);
        check("drain.b", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/time_unit_counter.md
Name: time_unit_counter

Overview:
- Generic, parametrised time-field counter for the millennium clock: one instance per field (seconds, minutes, hours, day, month, year).
- Runs in a single clock domain and counts MIN_VAL..max with wrap and a one-cycle carry pulse to the next field.
- While the field is selected for setting, counting is frozen and the value is adjusted from rising edges of up/down.
- Supports a dynamic upper bound (days-per-month) with automatic clamping when the bound shrinks.

Parameters:
- WIDTH, 6, bit width of the value and of max_dyn.
- MIN_VAL, 0, lowest legal value (1 for day/month fields).
- MAX_VAL, 59, static highest legal value; used when USE_DYN_MAX=0.
- USE_DYN_MAX, 0, 1 = upper bound taken from the max_dyn port instead of MAX_VAL.
- SEL_W, 3, width of select_item.
- SELECT_CODE, 3'b000, select_item code that puts this field into adjust mode.

Ports:
- clk_1Hz  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk_1Hz.
- en_1  input  1  count request / carry-in from the lower field, one-cycle pulse or level.
- up  input  1  debounced, clk_1Hz-synchronous increment button (level).
- down  input  1  debounced, clk_1Hz-synchronous decrement button (level).
- select_item  input  SEL_W  field currently being set.
- max_dyn  input  WIDTH  dynamic upper bound; ignored when USE_DYN_MAX=0.
- value  output  WIDTH  current field value (registered).
- carry_out  output  1  one-cycle overflow pulse to the next field (registered).
- adj_active  output  1  registered flag, high while this field is in adjust mode.

Behaviour:
- Reset (rst_n=0 at a clock edge): value=MIN_VAL, carry_out=0, adj_active=0, up_q=0, down_q=0. Reset overrides all other inputs, including mid-adjust and mid-carry.
- Effective bound: eff_max = USE_DYN_MAX ? max_dyn : MAX_VAL. If max_dyn < MIN_VAL, eff_max = MIN_VAL.
- Edge detect:
  - up_q and down_q register up and down every cycle, in both modes.
  - up_rise = up & ~up_q; down_rise = down & ~down_q.
  - A button already held when the field is selected produces no edge.
- Mode: adj = (select_item == SELECT_CODE), evaluated combinationally each cycle. adj_active <= adj, so the flag lags adj by one cycle.
- Count mode (adj=0), priority order:
  1. en_1=1 and value >= eff_max: value <= MIN_VAL, carry_out <= 1.
  2. en_1=1 otherwise: value <= value+1, carry_out <= 0.
  3. en_1=0 and value > eff_max: value <= eff_max, carry_out <= 0 (clamp).
  4. Else: hold, carry_out <= 0.
  - up/down edges are ignored.
- Adjust mode (adj=1):
  - en_1 is ignored; carry_out <= 0 every cycle, and adjustments never create carry.
  - value > eff_max: value <= eff_max; edges ignored that cycle.
  - up_rise & ~down_rise: value <= (value == eff_max) ? MIN_VAL : value+1.
  - down_rise & ~up_rise: value <= (value == MIN_VAL) ? eff_max : value-1.
  - Both rising in the same cycle, or neither: hold.
- Timing:
  - Latency of every update is one cycle: the input is sampled at edge N and the result is visible after edge N.
  - carry_out is high for exactly the one cycle following the wrapping edge. A continuously-high en_1 produces one carry per wrap.
- Arithmetic: unsigned, WIDTH bits. MAX_VAL < 2^WIDTH is required; with that constraint the +1/-1 results never overflow WIDTH.
- Leaving adjust mode: counting resumes on the next en_1 from the adjusted value. No pending carry is produced.

Test Plan:
- Reset, then 60 en_1 pulses (defaults) -> value steps 0..59, then 0; carry_out=1 for exactly the one cycle after the 59->0 edge, and 0 at every other cycle.
- MIN_VAL=1, USE_DYN_MAX=1, max_dyn=31, value=31, then max_dyn=28 with en_1=0 -> value=28 next cycle, carry_out=0. Then en_1=1 -> value=1, carry_out=1.
- select_item=SELECT_CODE, value=0, single down press -> value=59. Then up held 5 cycles -> exactly one increment, value=0. en_1 pulses during this time -> no change, carry_out stays 0.
- up and down rising in the same cycle in adjust mode, value=30 -> value stays 30. up held while select_item switches into SELECT_CODE -> no increment until up is released and pressed again.
- rst_n=0 for one cycle in the same cycle as an en_1 at value=59 -> value=MIN_VAL, carry_out=0, adj_active=0 after the edge; normal counting resumes on the next cycle.
